cdb_broadcaster: RTL and testbench

//  Transmit side of the common data bus (CDB) that reservation-station lines snoop.
//  - Collects results from NUM_SRC functional units, each through a per-source FIFO.
//  - Picks one result per cycle with round-robin arbitration.
//  - Drives the registered broadcast triple bus_en / bus_ref_id / bus_data to every RS line and the ROB.
//  - Consumers never back-pressure the CDB; only sources stall, via src_ready.

---
 rtl/cdb_broadcaster.sv | 169 ++++++++++++++++
 tb/tb_cdb_broadcaster.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_broadcaster.sv
// CDB transmit side: per-source result FIFOs, round-robin pick, registered broadcast.
// Optional build macro CDB_BYPASS_EN lets an empty source's incoming beat reach the bus directly.
module cdb_broadcaster #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REF_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*REF_WIDTH-1:0]  src_ref_id,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic                          bus_en,
    output logic [REF_WIDTH-1:0]          bus_ref_id,
    output logic [DATA_WIDTH-1:0]         bus_data
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned RR_W  = $clog2(NUM_SRC);
    localparam int unsigned ENT_W = REF_WIDTH + DATA_WIDTH;

    typedef logic [ENT_W-1:0] entry_t;

    entry_t                mem_q    [NUM_SRC][FIFO_DEPTH];
    entry_t                mem_d    [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q [NUM_SRC];
    logic [PTR_W-1:0]      rd_ptr_d [NUM_SRC];
    logic [PTR_W-1:0]      wr_ptr_q [NUM_SRC];
    logic [PTR_W-1:0]      wr_ptr_d [NUM_SRC];
    logic [CNT_W-1:0]      cnt_q    [NUM_SRC];
    logic [CNT_W-1:0]      cnt_d    [NUM_SRC];
    logic [RR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  bus_en_q, bus_en_d;
    logic [REF_WIDTH-1:0]  bus_ref_id_q, bus_ref_id_d;
    logic [DATA_WIDTH-1:0] bus_data_q, bus_data_d;

    logic [NUM_SRC-1:0]    empty, full, push, req;
    logic [NUM_SRC-1:0]    pop, bypass, wr;
    logic                  gnt_vld;
    logic [RR_W-1:0]       gnt_idx;

    always_comb begin
        empty     = '0;
        full      = '0;
        push      = '0;
        req       = '0;
        src_ready = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            empty[i]     = (cnt_q[i] == '0);
            full[i]      = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
            src_ready[i] = rst && !full[i];
            push[i]      = src_valid[i] && src_ready[i] && !flush;
`ifdef CDB_BYPASS_EN
            req[i]       = !empty[i] || push[i];
`else
            req[i]       = !empty[i];
`endif
        end
    end

    // Two passes: sources at or above rr_ptr first, then the wrapped-around ones.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!gnt_vld && req[i] && (i >= 32'(rr_ptr_q))) begin
                gnt_vld = 1'b1;
                gnt_idx = RR_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!gnt_vld && req[i] && (i < 32'(rr_ptr_q))) begin
                gnt_vld = 1'b1;
                gnt_idx = RR_W'(i);
            end
        end
    end

    always_comb begin
        pop    = '0;
        bypass = '0;
        wr     = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            pop[i]    = !flush && gnt_vld && (gnt_idx == RR_W'(i));
            bypass[i] = pop[i] && empty[i];
            wr[i]     = push[i] && !bypass[i];
        end
    end

    always_comb begin
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        rr_ptr_d     = rr_ptr_q;
        bus_en_d     = 1'b0;
        bus_ref_id_d = bus_ref_id_q;
        bus_data_d   = bus_data_q;
        if (flush) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                rd_ptr_d[i] = '0;
                wr_ptr_d[i] = '0;
                cnt_d[i]    = '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (pop[i]) begin
                    bus_en_d = 1'b1;
                    if (bypass[i]) begin
                        bus_ref_id_d = src_ref_id[i*REF_WIDTH +: REF_WIDTH];
                        bus_data_d   = src_data[i*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        {bus_ref_id_d, bus_data_d} = mem_q[i][rd_ptr_q[i]];
                        rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
                    end
                end
                if (wr[i]) begin
                    mem_d[i][wr_ptr_q[i]] = {src_ref_id[i*REF_WIDTH +: REF_WIDTH],
                                             src_data[i*DATA_WIDTH +: DATA_WIDTH]};
                    wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
                end
                if (wr[i] && !(pop[i] && !bypass[i])) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end else if (!wr[i] && pop[i] && !bypass[i]) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
            if (gnt_vld) begin
                rr_ptr_d = (gnt_idx == RR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + RR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            rr_ptr_q     <= '0;
            bus_en_q     <= 1'b0;
            bus_ref_id_q <= '0;
            bus_data_q   <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            bus_en_q     <= bus_en_d;
            bus_ref_id_q <= bus_ref_id_d;
            bus_data_q   <= bus_data_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus_en     = bus_en_q;
    assign bus_ref_id = bus_ref_id_q;
    assign bus_data   = bus_data_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Randomized and directed stimulus for cdb_broadcaster, checked every cycle against a queue-based model.
module tb_cdb_broadcaster;

    localparam int N  = 4;
    localparam int D  = 2;
    localparam int DW = 32;
    localparam int RW = 32;
`ifdef CDB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic [N-1:0]    src_valid = '0;
    logic [N-1:0]    src_ready;
    logic [N*RW-1:0] src_ref_id = '0;
    logic [N*DW-1:0] src_data = '0;
    logic            bus_en;
    logic [RW-1:0]   bus_ref_id;
    logic [DW-1:0]   bus_data;

    cdb_broadcaster #(
        .NUM_SRC   (N),
        .FIFO_DEPTH(D),
        .DATA_WIDTH(DW),
        .REF_WIDTH (RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_ref_id(src_ref_id),
        .src_data  (src_data),
        .bus_en    (bus_en),
        .bus_ref_id(bus_ref_id),
        .bus_data  (bus_data)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] id;
        logic [31:0] data;
    } beat_t;

    beat_t        mq[N][$];
    int           m_rr = 0;
    logic         m_en = 1'b0;
    logic [31:0]  m_ref = '0;
    logic [31:0]  m_data = '0;
    logic [N-1:0] m_acc = '0;
    int           checks = 0;
    int           errors = 0;
    int unsigned  next_id = 1000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Applies the broadcaster's rules for one clock edge to the reference queues.
    task automatic model_edge(input logic [N-1:0] rdy);
        int    g;
        int    byp;
        int    s;
        beat_t b;
        g   = -1;
        byp = -1;
        if (!rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_rr   = 0;
            m_en   = 1'b0;
            m_ref  = '0;
            m_data = '0;
            m_acc  = '0;
        end else if (flush) begin
            m_acc = '0;
            for (int i = 0; i < N; i++) mq[i].delete();
            m_en = 1'b0;
        end else begin
            m_acc = src_valid & rdy;
            for (int k = 0; k < N; k++) begin
                s = (m_rr + k) % N;
                if (g < 0 && (mq[s].size() > 0 || (BYPASS && m_acc[s]))) g = s;
            end
            if (g >= 0) begin
                m_en = 1'b1;
                if (mq[g].size() > 0) begin
                    b      = mq[g].pop_front();
                    m_ref  = b.id;
                    m_data = b.data;
                end else begin
                    m_ref  = src_ref_id[g*RW +: RW];
                    m_data = src_data[g*DW +: DW];
                    byp    = g;
                end
                m_rr = (g + 1) % N;
            end else begin
                m_en = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (m_acc[i] && i != byp) begin
                    b.id   = src_ref_id[i*RW +: RW];
                    b.data = src_data[i*DW +: DW];
                    mq[i].push_back(b);
                end
            end
        end
    endtask

    task automatic cycle();
        logic [N-1:0] rdy;
        #1;
        for (int i = 0; i < N; i++) rdy[i] = rst && (mq[i].size() < D);
        check_eq("src_ready", 32'(src_ready), 32'(rdy));
        @(posedge clk);
        model_edge(rdy);
        #1;
        check_eq("bus_en", 32'(bus_en), 32'(m_en));
        check_eq("bus_ref_id", bus_ref_id, m_ref);
        check_eq("bus_data", bus_data, m_data);
        @(negedge clk);
    endtask

    task automatic drive(input int s, input logic [31:0] id, input logic [31:0] d);
        src_valid[s]           = 1'b1;
        src_ref_id[s*RW +: RW] = id;
        src_data[s*DW +: DW]   = d;
    endtask

    task automatic idle(input int n);
        src_valid = '0;
        flush     = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        int unsigned ids[N];

        // Reset held with all sources requesting
        rst = 1'b0;
        src_valid = '1;
        for (int k = 0; k < 3; k++) cycle();
        rst = 1'b1;
        idle(3);

        // Single beat
        drive(0, 32'd5, 32'hDEADBEEF);
        cycle();
        idle(4);

        // Round-robin across all sources, then a sparse pair
        for (int s = 0; s < N; s++) drive(s, 32'(10 + s), 32'hA000_0000 + 32'(s));
        cycle();
        idle(6);
        drive(1, 32'd21, 32'hB000_0021);
        drive(3, 32'd23, 32'hB000_0023);
        cycle();
        idle(4);

        // One source streaming every cycle
        ids[2] = 1;
        for (int k = 0; k < 12; k++) begin
            src_valid = '0;
            drive(2, ids[2], ids[2] ^ 32'h5A5A_0000);
            cycle();
            if (m_acc[2]) ids[2]++;
        end
        // All sources saturated
        for (int s = 0; s < N; s++) ids[s] = 32'(200 + 40 * s);
        for (int k = 0; k < 24; k++) begin
            for (int s = 0; s < N; s++) drive(s, ids[s], ids[s] + 32'h0100_0000);
            cycle();
            for (int s = 0; s < N; s++) if (m_acc[s]) ids[s]++;
        end
        idle(8);

        // Flush with queued beats and a same-cycle push
        for (int k = 0; k < 3; k++) begin
            src_valid = '0;
            drive(0, 32'(40 + k), 32'hC000_0000 + 32'(k));
            drive(1, 32'(50 + k), 32'hC100_0000 + 32'(k));
            cycle();
        end
        src_valid = '0;
        drive(0, 32'd99, 32'h0000_0099);
        flush = 1'b1;
        cycle();
        idle(4);

        // Reset while beats are queued
        for (int s = 0; s < 3; s++) drive(s, 32'(60 + s), 32'hD000_0000 + 32'(s));
        cycle();
        src_valid = '0;
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        idle(5);

        // Random traffic with occasional flush and reset
        for (int k = 0; k < 800; k++) begin
            src_valid = '0;
            for (int s = 0; s < N; s++) begin
                if ($urandom_range(0, 99) < 55) begin
                    drive(s, next_id, $urandom());
                    next_id++;
                end
            end
            flush = ($urandom_range(0, 99) < 3);
            rst   = ($urandom_range(0, 199) != 0);
            cycle();
        end
        rst = 1'b1;
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
